// File: rtl/metaballs_pkg.sv
// Shared screen geometry, coordinate width and sequencer state encoding
// for the metaball position and pixel stages.
package metaballs_pkg;

  localparam int unsigned SCREEN_WIDTH  = 800;
  localparam int unsigned SCREEN_HEIGHT = 600;
  localparam int unsigned BALL_DIM      = 25;
  localparam int unsigned COORD_W       = 10;

  localparam logic [COORD_W-1:0] MAX_X = COORD_W'(SCREEN_WIDTH - BALL_DIM);
  localparam logic [COORD_W-1:0] MAX_Y = COORD_W'(SCREEN_HEIGHT - BALL_DIM);

  typedef enum logic {
    IDLE,
    UPDATE
  } seq_state_t;

endpackage

// File: rtl/ball_axis_step.sv
// One-axis bounce step: moves pos by speed toward the current direction,
// clamping to [0, max_pos] and reversing direction at either wall.
module ball_axis_step
  import metaballs_pkg::*;
(
  input  logic [COORD_W-1:0] pos,
  input  logic               dir,
  input  logic [COORD_W-1:0] speed,
  input  logic [COORD_W-1:0] max_pos,
  output logic [COORD_W-1:0] next_pos,
  output logic               next_dir
);

  logic [COORD_W:0] sum;

  always_comb begin
    sum      = {1'b0, pos} + {1'b0, speed};
    next_pos = pos;
    next_dir = dir;
    if (dir) begin
      if (sum >= {1'b0, max_pos}) begin
        next_pos = max_pos;
        next_dir = 1'b0;
      end else begin
        next_pos = sum[COORD_W-1:0];
      end
    end else begin
      if (pos <= speed) begin
        next_pos = '0;
        next_dir = 1'b1;
      end else begin
        next_pos = pos - speed;
      end
    end
  end

endmodule

// File: rtl/ball_motion.sv
// Ball position engine: on each v_sync falling edge, walks all balls one per
// clock and advances them, exposing stable packed coordinates to the pixel stage.
module ball_motion
  import metaballs_pkg::*;
#(
  parameter int unsigned                     NUM_BALLS  = 2,
  parameter int unsigned                     BALL_SPEED = 5,
  parameter logic [COORD_W*NUM_BALLS-1:0]    INIT_X     = {10'd50, 10'd150},
  parameter logic [COORD_W*NUM_BALLS-1:0]    INIT_Y     = {10'd250, 10'd100}
) (
  input  logic                         clk_50mhz,
  input  logic                         reset_n,
  input  logic                         v_sync,
  input  logic                         enable,
  output logic [COORD_W*NUM_BALLS-1:0] ball_x,
  output logic [COORD_W*NUM_BALLS-1:0] ball_y,
  output logic                         update_busy,
  output logic                         update_done,
  output logic                         overrun,
  output logic [15:0]                  frame_count
);

  localparam int unsigned IDX_W = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1;
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_BALLS - 1);
  localparam logic [COORD_W-1:0] SPEED    = COORD_W'(BALL_SPEED);

  if (NUM_BALLS < 1 || NUM_BALLS > 16) begin : g_bad_num
    $error("ball_motion: NUM_BALLS must be 1..16");
  end
  if (BALL_SPEED >= 575) begin : g_bad_speed
    $error("ball_motion: BALL_SPEED must be below 575");
  end

  seq_state_t       state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic             busy_n, done_n;
  logic             v_sync_q;
  logic             tick;

  logic [COORD_W-1:0] pos_x [NUM_BALLS];
  logic [COORD_W-1:0] pos_y [NUM_BALLS];
  logic               vx    [NUM_BALLS];
  logic               vy    [NUM_BALLS];

  logic [COORD_W-1:0] nx, ny;
  logic               nvx, nvy;

  for (genvar g = 0; g < NUM_BALLS; g++) begin : g_ball
    if (INIT_X[COORD_W*g +: COORD_W] > MAX_X || INIT_Y[COORD_W*g +: COORD_W] > MAX_Y) begin : g_bad_init
      $error("ball_motion: INIT position beyond axis maximum");
    end
    assign ball_x[COORD_W*g +: COORD_W] = pos_x[g];
    assign ball_y[COORD_W*g +: COORD_W] = pos_y[g];
  end

  assign tick = v_sync_q & ~v_sync;

  ball_axis_step u_step_x (
    .pos      (pos_x[idx]),
    .dir      (vx[idx]),
    .speed    (SPEED),
    .max_pos  (MAX_X),
    .next_pos (nx),
    .next_dir (nvx)
  );

  ball_axis_step u_step_y (
    .pos      (pos_y[idx]),
    .dir      (vy[idx]),
    .speed    (SPEED),
    .max_pos  (MAX_Y),
    .next_pos (ny),
    .next_dir (nvy)
  );

  always_comb begin
    state_n = state;
    idx_n   = idx;
    busy_n  = update_busy;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (tick && enable) begin
          state_n = UPDATE;
          idx_n   = '0;
          busy_n  = 1'b1;
        end
      end
      UPDATE: begin
        if (idx == LAST_IDX) begin
          state_n = IDLE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end else begin
          idx_n = idx + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // v_sync_q resets high so a low v_sync at release is not seen as a tick
  always_ff @(posedge clk_50mhz or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      idx         <= '0;
      update_busy <= 1'b0;
      update_done <= 1'b0;
      overrun     <= 1'b0;
      frame_count <= '0;
      v_sync_q    <= 1'b1;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      update_busy <= busy_n;
      update_done <= done_n;
      v_sync_q    <= v_sync;
      if (tick) begin
        frame_count <= frame_count + 1'b1;
      end
      if (tick && state == UPDATE) begin
        overrun <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_50mhz or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_BALLS; i++) begin
        pos_x[i] <= INIT_X[COORD_W*i +: COORD_W];
        pos_y[i] <= INIT_Y[COORD_W*i +: COORD_W];
        vx[i]    <= 1'b1;
        vy[i]    <= 1'b1;
      end
    end else if (state == UPDATE) begin
      pos_x[idx] <= nx;
      pos_y[idx] <= ny;
      vx[idx]    <= nvx;
      vy[idx]    <= nvy;
    end
  end

endmodule

// File: tb/tb_ball_motion.sv
// Scoreboarded bench for ball_motion: stimulus queues the expected positions
// of each frame update; per-instance monitors compare on update_done.
module tb_ball_motion;

  typedef struct {
    logic [159:0] x;
    logic [159:0] y;
    logic [15:0]  fc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  exp_t e0, e1, e2;

  logic rn0, rn_all;
  logic vs0, vs1, vs2;
  logic en0, en1, en2;

  logic [19:0]  bx0, by0, bx1, by1;
  logic [159:0] bx2, by2;
  logic         busy0, done0, ovr0;
  logic         busy1, done1, ovr1;
  logic         busy2, done2, ovr2;
  logic [15:0]  fc0, fc1, fc2;

  ball_motion u0 (
    .clk_50mhz (clk), .reset_n (rn0), .v_sync (vs0), .enable (en0),
    .ball_x (bx0), .ball_y (by0), .update_busy (busy0), .update_done (done0),
    .overrun (ovr0), .frame_count (fc0)
  );

  ball_motion #(.INIT_X({10'd50, 10'd770})) u1 (
    .clk_50mhz (clk), .reset_n (rn_all), .v_sync (vs1), .enable (en1),
    .ball_x (bx1), .ball_y (by1), .update_busy (busy1), .update_done (done1),
    .overrun (ovr1), .frame_count (fc1)
  );

  ball_motion #(
    .NUM_BALLS (16),
    .INIT_X    ({16{10'd100}}),
    .INIT_Y    ({16{10'd200}})
  ) u2 (
    .clk_50mhz (clk), .reset_n (rn_all), .v_sync (vs2), .enable (en2),
    .ball_x (bx2), .ball_y (by2), .update_busy (busy2), .update_done (done2),
    .overrun (ovr2), .frame_count (fc2)
  );

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [159:0] x, input logic [159:0] y, input logic [15:0] fc);
    exp_t e;
    e.x  = x;
    e.y  = y;
    e.fc = fc;
    return e;
  endfunction

  always @(negedge clk) begin
    if (done0) begin
      if (q0.size() == 0) chk("u0_done_spurious", done0, 1'b0);
      else begin
        e0 = q0.pop_front();
        chk("u0_ball_x", bx0, e0.x);
        chk("u0_ball_y", by0, e0.y);
        chk("u0_frame_count", fc0, e0.fc);
      end
    end
  end

  always @(negedge clk) begin
    if (done1) begin
      if (q1.size() == 0) chk("u1_done_spurious", done1, 1'b0);
      else begin
        e1 = q1.pop_front();
        chk("u1_x0", bx1[9:0], e1.x);
        chk("u1_frame_count", fc1, e1.fc);
      end
    end
  end

  always @(negedge clk) begin
    if (done2) begin
      if (q2.size() == 0) chk("u2_done_spurious", done2, 1'b0);
      else begin
        e2 = q2.pop_front();
        chk("u2_ball_x", bx2, e2.x);
        chk("u2_ball_y", by2, e2.y);
        chk("u2_frame_count", fc2, e2.fc);
      end
    end
  end

  initial begin
    int x0;
    rn0 = 1'b0; rn_all = 1'b0;
    vs0 = 1'b1; vs1 = 1'b1; vs2 = 1'b1;
    en0 = 1'b1; en1 = 1'b1; en2 = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ball_x", bx0, {10'd50, 10'd150});
    chk("rst_ball_y", by0, {10'd250, 10'd100});
    chk("rst_busy", busy0, 1'b0);
    chk("rst_done", done0, 1'b0);
    chk("rst_overrun", ovr0, 1'b0);
    chk("rst_frame_count", fc0, 16'd0);
    rn0 = 1'b1; rn_all = 1'b1;
    repeat (5) @(negedge clk);

    // single frame update with latency checks
    q0.push_back(mk({10'd55, 10'd155}, {10'd255, 10'd105}, 16'd1));
    vs0 = 1'b0;
    @(negedge clk);
    chk("t1_busy_c1", busy0, 1'b1);
    chk("t1_x_unchanged", bx0, {10'd50, 10'd150});
    chk("t1_frame_count", fc0, 16'd1);
    @(negedge clk);
    chk("t1_ball0_x", bx0[9:0], 10'd155);
    chk("t1_ball0_y", by0[9:0], 10'd105);
    chk("t1_ball1_x_pending", bx0[19:10], 10'd50);
    chk("t1_busy_c2", busy0, 1'b1);
    @(negedge clk);
    chk("t1_busy_c3", busy0, 1'b0);
    chk("t1_done", done0, 1'b1);
    @(negedge clk);
    chk("t1_done_pulse", done0, 1'b0);
    repeat (116) @(negedge clk);
    vs0 = 1'b1;
    @(negedge clk);
    chk("hold_low_one_tick", fc0, 16'd1);

    // frozen while disabled
    en0 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      vs0 = 1'b0;
      repeat (3) @(negedge clk);
      vs0 = 1'b1;
      repeat (3) @(negedge clk);
    end
    chk("dis_frame_count", fc0, 16'd4);
    chk("dis_ball_x", bx0, {10'd55, 10'd155});
    chk("dis_ball_y", by0, {10'd255, 10'd105});
    chk("dis_busy", busy0, 1'b0);

    // reset between ball0 and ball1 writes
    en0 = 1'b1;
    vs0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_ball0_x", bx0[9:0], 10'd160);
    rn0 = 1'b0;
    #1;
    chk("mid_rst_ball_x", bx0, {10'd50, 10'd150});
    chk("mid_rst_ball_y", by0, {10'd250, 10'd100});
    chk("mid_rst_busy", busy0, 1'b0);
    chk("mid_rst_frame_count", fc0, 16'd0);
    vs0 = 1'b1;
    repeat (3) @(negedge clk);
    rn0 = 1'b1;
    repeat (5) @(negedge clk);

    // right-wall bounce then left-wall bounce on ball0 x
    for (int k = 1; k <= 157; k++) begin
      if (k == 1)        x0 = 775;
      else if (k <= 155) x0 = 775 - 5 * (k - 1);
      else if (k == 156) x0 = 0;
      else               x0 = 5;
      q1.push_back(mk(160'(x0), '0, 16'(k)));
      vs1 = 1'b0;
      @(negedge clk);
      vs1 = 1'b1;
      repeat (4) @(negedge clk);
    end

    // 16 balls with a second tick mid-sequence
    q2.push_back(mk({16{10'd105}}, {16{10'd205}}, 16'd2));
    vs2 = 1'b0;
    @(negedge clk);
    vs2 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("ovr_before", ovr2, 1'b0);
    @(negedge clk);
    vs2 = 1'b0;
    @(negedge clk);
    chk("ovr_set", ovr2, 1'b1);
    chk("ovr_busy", busy2, 1'b1);
    vs2 = 1'b1;
    repeat (11) @(negedge clk);
    chk("ovr_busy_last", busy2, 1'b1);
    @(negedge clk);
    chk("ovr_busy_end", busy2, 1'b0);
    chk("ovr_done", done2, 1'b1);
    repeat (10) @(negedge clk);
    chk("ovr_sticky", ovr2, 1'b1);
    chk("ovr_frame_count", fc2, 16'd2);

    repeat (5) @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
